control_sequencer: RTL and testbench

Hardwired control unit sitting directly upstream of `DataPath`. It consumes the instruction word latched in IR and drives every datapath strobe, cycle by cycle, for fetch and for register-format execution. These strobes include the register in/out selects, PC/MAR/MDR/IR/Y/Z/HI/LO enables, the ALU operation lines, and `Read`/`IncPC`. It replaces hand-sequenced testbench stimulus with a Moore state machine and adds memory-ready wait, halt and illegal-opcode handling.

---
 rtl/cpu_ctrl_pkg.sv | 72 +++++++
 rtl/reg_select_dec.sv | 15 +
 rtl/control_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, IR field positions,
// state encoding and the opcode-to-class / opcode-to-ALU-line decode helpers.
package cpu_ctrl_pkg;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RA_MSB  = 26;
   localparam int RA_LSB  = 23;
   localparam int RB_MSB  = 22;
   localparam int RB_LSB  = 19;
   localparam int RC_MSB  = 18;
   localparam int RC_LSB  = 15;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_MUL  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam int ALU_W = 13;

   typedef enum logic [2:0] {
      ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
   } state_e;

   typedef enum logic [2:0] {
      CLS_ALU3, CLS_MULDIV, CLS_UNARY, CLS_NOP, CLS_HALT, CLS_ILLEGAL
   } op_class_e;

   function automatic op_class_e classifyOp(input logic [4:0] opc);
      case (opc)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
         OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  return CLS_ALU3;
         OP_MUL, OP_DIV:                   return CLS_MULDIV;
         OP_NEG, OP_NOT:                   return CLS_UNARY;
         OP_NOP:                           return CLS_NOP;
         OP_HALT:                          return CLS_HALT;
         default:                          return CLS_ILLEGAL;
      endcase
   endfunction

   // Bit order: ADD SUB AND OR SHR SHRA SHL ROR ROL MUL DIV NEG NOT (ADD is the MSB)
   function automatic logic [ALU_W-1:0] aluLine(input logic [4:0] opc);
      case (opc)
         OP_ADD:  return 13'b1_0000_0000_0000;
         OP_SUB:  return 13'b0_1000_0000_0000;
         OP_AND:  return 13'b0_0100_0000_0000;
         OP_OR:   return 13'b0_0010_0000_0000;
         OP_SHR:  return 13'b0_0001_0000_0000;
         OP_SHRA: return 13'b0_0000_1000_0000;
         OP_SHL:  return 13'b0_0000_0100_0000;
         OP_ROR:  return 13'b0_0000_0010_0000;
         OP_ROL:  return 13'b0_0000_0001_0000;
         OP_MUL:  return 13'b0_0000_0000_1000;
         OP_DIV:  return 13'b0_0000_0000_0100;
         OP_NEG:  return 13'b0_0000_0000_0010;
         OP_NOT:  return 13'b0_0000_0000_0001;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/reg_select_dec.sv
// Converts a 4-bit register field plus enable into a one-hot register select vector.
module reg_select_dec #(
   parameter int NUM_REGS = 16
) (
   input  logic [3:0]          field_i,
   input  logic                en_i,
   output logic [NUM_REGS-1:0] sel_o
);

   always_comb begin
      sel_o = '0;
      if (en_i) sel_o[field_i] = 1'b1;
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: sequences fetch and register-format execute strobes
// for DataPath, with memory-ready wait, halt/stop and illegal-opcode handling.
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int NUM_REGS = 16
) (
   input  logic                Clock,
   input  logic                Clear,
   input  logic [31:0]         IR,
   input  logic                MemRdy,
   input  logic                Stop,
   output logic                PCout,
   output logic                PCin,
   output logic                IncPC,
   output logic                MARin,
   output logic                MDRin,
   output logic                MDRout,
   output logic                IRin,
   output logic                Yin,
   output logic                Zin,
   output logic                Zhighout,
   output logic                Zlowout,
   output logic                HIin,
   output logic                LOin,
   output logic                Read,
   output logic [NUM_REGS-1:0] Rin,
   output logic [NUM_REGS-1:0] Rout,
   output logic                ADD,
   output logic                SUB,
   output logic                AND,
   output logic                OR,
   output logic                SHR,
   output logic                SHRA,
   output logic                SHL,
   output logic                ROR,
   output logic                ROL,
   output logic                MUL,
   output logic                DIV,
   output logic                NEG,
   output logic                NOT,
   output logic                Run,
   output logic                Illegal
);

   state_e           state_q, state_d, afterExec;
   op_class_e        opClass;
   logic [4:0]       opcode;
   logic [3:0]       raField, rbField, rcField;
   logic [3:0]       rinField, routField;
   logic             rinEn, routEn, aluEn;
   logic [ALU_W-1:0] aluSel;
   logic             unusedIrBits;

   assign opcode       = IR[OPC_MSB:OPC_LSB];
   assign raField      = IR[RA_MSB:RA_LSB];
   assign rbField      = IR[RB_MSB:RB_LSB];
   assign rcField      = IR[RC_MSB:RC_LSB];
   assign unusedIrBits = ^IR[RC_LSB-1:0];
   assign opClass      = classifyOp(opcode);
   assign afterExec    = Stop ? ST_HALT : ST_T0;

   // Stop only matters on the transition out of an instruction's final execute state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_T0: state_d = ST_T1;
         ST_T1: if (MemRdy) state_d = ST_T2;
         ST_T2: state_d = ST_T3;
         ST_T3: begin
            case (opClass)
               CLS_ALU3, CLS_MULDIV, CLS_UNARY: state_d = ST_T4;
               CLS_HALT:                        state_d = ST_HALT;
               default:                         state_d = afterExec;
            endcase
         end
         ST_T4: begin
            case (opClass)
               CLS_ALU3, CLS_MULDIV: state_d = ST_T5;
               CLS_UNARY:            state_d = afterExec;
               default:              state_d = ST_T0;
            endcase
         end
         ST_T5: begin
            case (opClass)
               CLS_MULDIV: state_d = ST_T6;
               CLS_ALU3:   state_d = afterExec;
               default:    state_d = ST_T0;
            endcase
         end
         ST_T6:   state_d = afterExec;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_T0;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Clear) state_q <= ST_T0;
      else       state_q <= state_d;
   end

   // Strobes come straight from state and the live IR; Clear blanks them all immediately.
   always_comb begin
      {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin} = '0;
      {Yin, Zin, Zhighout, Zlowout, HIin, LOin, Read}  = '0;
      rinField  = raField;
      routField = rbField;
      rinEn     = 1'b0;
      routEn    = 1'b0;
      aluEn     = 1'b0;
      Illegal   = 1'b0;
      if (!Clear) begin
         case (state_q)
            ST_T0: {PCout, MARin, IncPC, Zin} = 4'b1111;
            ST_T1: {Zlowout, PCin, Read, MDRin} = 4'b1111;
            ST_T2: {MDRout, IRin} = 2'b11;
            ST_T3: begin
               case (opClass)
                  CLS_ALU3: begin
                     routEn = 1'b1;
                     Yin    = 1'b1;
                  end
                  CLS_MULDIV: begin
                     routField = raField;
                     routEn    = 1'b1;
                     Yin       = 1'b1;
                  end
                  CLS_UNARY: begin
                     routEn = 1'b1;
                     aluEn  = 1'b1;
                     Zin    = 1'b1;
                  end
                  CLS_ILLEGAL: Illegal = 1'b1;
                  default: ;
               endcase
            end
            ST_T4: begin
               case (opClass)
                  CLS_ALU3: begin
                     routField = rcField;
                     routEn    = 1'b1;
                     aluEn     = 1'b1;
                     Zin       = 1'b1;
                  end
                  CLS_MULDIV: begin
                     routEn = 1'b1;
                     aluEn  = 1'b1;
                     Zin    = 1'b1;
                  end
                  CLS_UNARY: begin
                     Zlowout = 1'b1;
                     rinEn   = 1'b1;
                  end
                  default: ;
               endcase
            end
            ST_T5: begin
               case (opClass)
                  CLS_ALU3: begin
                     Zlowout = 1'b1;
                     rinEn   = 1'b1;
                  end
                  CLS_MULDIV: {Zlowout, LOin} = 2'b11;
                  default: ;
               endcase
            end
            ST_T6: if (opClass == CLS_MULDIV) {Zhighout, HIin} = 2'b11;
            default: ;
         endcase
      end
   end

   assign aluSel = aluEn ? aluLine(opcode) : '0;
   assign {ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT} = aluSel;
   assign Run = (state_q != ST_HALT);

   reg_select_dec #(.NUM_REGS(NUM_REGS)) uRinDec (
      .field_i (rinField),
      .en_i    (rinEn),
      .sel_o   (Rin)
   );

   reg_select_dec #(.NUM_REGS(NUM_REGS)) uRoutDec (
      .field_i (routField),
      .en_i    (routEn),
      .sel_o   (Rout)
   );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: every cycle of each instruction is compared
// against a hand-written strobe vector.
module tb_control_sequencer;

   logic        Clock, Clear, MemRdy, Stop;
   logic [31:0] IR;
   logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin;
   logic        Zhighout, Zlowout, HIin, LOin, Read;
   logic [15:0] Rin, Rout;
   logic        ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT;
   logic        Run, Illegal;

   int total = 0;
   int bad   = 0;

   localparam logic [13:0] M_PCOUT = 14'h2000, M_PCIN  = 14'h1000, M_INCPC = 14'h0800;
   localparam logic [13:0] M_MARIN = 14'h0400, M_MDRIN = 14'h0200, M_MDROUT = 14'h0100;
   localparam logic [13:0] M_IRIN  = 14'h0080, M_YIN   = 14'h0040, M_ZIN   = 14'h0020;
   localparam logic [13:0] M_ZHI   = 14'h0010, M_ZLO   = 14'h0008, M_HIIN  = 14'h0004;
   localparam logic [13:0] M_LOIN  = 14'h0002, M_READ  = 14'h0001, M_NONE  = 14'h0000;

   localparam logic [12:0] A_NONE = 13'h0000, A_ADD = 13'h1000, A_AND = 13'h0400;
   localparam logic [12:0] A_MUL  = 13'h0008, A_NOT = 13'h0001;

   localparam logic [13:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
   localparam logic [13:0] F1 = M_ZLO | M_PCIN | M_READ | M_MDRIN;
   localparam logic [13:0] F2 = M_MDROUT | M_IRIN;

   logic [13:0] strobeObs;
   logic [12:0] aluObs;
   assign strobeObs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin,
                       Zhighout, Zlowout, HIin, LOin, Read};
   assign aluObs    = {ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT};

   control_sequencer #(.NUM_REGS(16)) dut (
      .Clock(Clock), .Clear(Clear), .IR(IR), .MemRdy(MemRdy), .Stop(Stop),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout),
      .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin), .Read(Read),
      .Rin(Rin), .Rout(Rout),
      .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR), .SHRA(SHRA), .SHL(SHL),
      .ROR(ROR), .ROL(ROL), .MUL(MUL), .DIV(DIV), .NEG(NEG), .NOT(NOT),
      .Run(Run), .Illegal(Illegal)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   // Compares the whole output set for the current cycle, then advances one clock.
   task automatic expectCycle(input string tag, input logic [13:0] s, input logic [12:0] a,
                              input logic [15:0] rin, input logic [15:0] rout,
                              input logic run, input logic ill);
      checkOutput(tag, {3'b0, strobeObs, aluObs, Rin, Rout, Run, Illegal},
                       {3'b0, s, a, rin, rout, run, ill});
      @(posedge Clock);
      #1;
   endtask

   task automatic expectFetch(input string tag);
      expectCycle({tag, "/T0"}, F0, A_NONE, 16'h0, 16'h0, 1'b1, 1'b0);
      expectCycle({tag, "/T1"}, F1, A_NONE, 16'h0, 16'h0, 1'b1, 1'b0);
      expectCycle({tag, "/T2"}, F2, A_NONE, 16'h0, 16'h0, 1'b1, 1'b0);
   endtask

   task automatic applyStimulus(input logic [31:0] ir, input logic rdy, input logic stop);
      IR     = ir;
      MemRdy = rdy;
      Stop   = stop;
   endtask

   task automatic pulseClear(input string tag);
      Clear = 1'b1;
      @(posedge Clock);
      #1;
      checkOutput({tag, "/clear"}, {3'b0, strobeObs, aluObs, Rin, Rout, Run, Illegal},
                                   {3'b0, M_NONE, A_NONE, 16'h0, 16'h0, 1'b1, 1'b0});
      Clear = 1'b0;
      #1;
   endtask

   initial begin
      Clear = 1'b1;
      applyStimulus(32'h28918000, 1'b1, 1'b0);
      pulseClear("reset");

      // and R1,R2,R3
      expectFetch("and");
      expectCycle("and/T3", M_YIN, A_NONE, 16'h0000, 16'h0004, 1'b1, 1'b0);
      expectCycle("and/T4", M_ZIN, A_AND, 16'h0000, 16'h0008, 1'b1, 1'b0);
      expectCycle("and/T5", M_ZLO, A_NONE, 16'h0002, 16'h0000, 1'b1, 1'b0);

      // same instruction with three wait cycles in T1
      applyStimulus(32'h28918000, 1'b0, 1'b0);
      expectCycle("wait/T0", F0, A_NONE, 16'h0, 16'h0, 1'b1, 1'b0);
      expectCycle("wait/T1a", F1, A_NONE, 16'h0, 16'h0, 1'b1, 1'b0);
      expectCycle("wait/T1b", F1, A_NONE, 16'h0, 16'h0, 1'b1, 1'b0);
      expectCycle("wait/T1c", F1, A_NONE, 16'h0, 16'h0, 1'b1, 1'b0);
      MemRdy = 1'b1;
      expectCycle("wait/T1d", F1, A_NONE, 16'h0, 16'h0, 1'b1, 1'b0);
      expectCycle("wait/T2", F2, A_NONE, 16'h0, 16'h0, 1'b1, 1'b0);
      expectCycle("wait/T3", M_YIN, A_NONE, 16'h0000, 16'h0004, 1'b1, 1'b0);
      expectCycle("wait/T4", M_ZIN, A_AND, 16'h0000, 16'h0008, 1'b1, 1'b0);
      expectCycle("wait/T5", M_ZLO, A_NONE, 16'h0002, 16'h0000, 1'b1, 1'b0);

      // mul R4,R5
      applyStimulus(32'h82280000, 1'b1, 1'b0);
      expectFetch("mul");
      expectCycle("mul/T3", M_YIN, A_NONE, 16'h0000, 16'h0010, 1'b1, 1'b0);
      expectCycle("mul/T4", M_ZIN, A_MUL, 16'h0000, 16'h0020, 1'b1, 1'b0);
      expectCycle("mul/T5", M_ZLO | M_LOIN, A_NONE, 16'h0, 16'h0, 1'b1, 1'b0);
      expectCycle("mul/T6", M_ZHI | M_HIIN, A_NONE, 16'h0, 16'h0, 1'b1, 1'b0);

      // not R6,R7
      applyStimulus(32'h93380000, 1'b1, 1'b0);
      expectFetch("not");
      expectCycle("not/T3", M_ZIN, A_NOT, 16'h0000, 16'h0080, 1'b1, 1'b0);
      expectCycle("not/T4", M_ZLO, A_NONE, 16'h0040, 16'h0000, 1'b1, 1'b0);

      // illegal opcode 11111
      applyStimulus(32'hF8000000, 1'b1, 1'b0);
      expectFetch("ill");
      expectCycle("ill/T3", M_NONE, A_NONE, 16'h0, 16'h0, 1'b1, 1'b1);

      // add R15,R15,R15
      applyStimulus(32'h1FFF8000, 1'b1, 1'b0);
      expectFetch("add15");
      expectCycle("add15/T3", M_YIN, A_NONE, 16'h0000, 16'h8000, 1'b1, 1'b0);
      expectCycle("add15/T4", M_ZIN, A_ADD, 16'h0000, 16'h8000, 1'b1, 1'b0);
      expectCycle("add15/T5", M_ZLO, A_NONE, 16'h8000, 16'h0000, 1'b1, 1'b0);

      // nop
      applyStimulus(32'hD0000000, 1'b1, 1'b0);
      expectFetch("nop");
      expectCycle("nop/T3", M_NONE, A_NONE, 16'h0, 16'h0, 1'b1, 1'b0);

      // halt opcode, then HALT holds until Clear
      applyStimulus(32'hD8000000, 1'b1, 1'b0);
      expectFetch("halt");
      expectCycle("halt/T3", M_NONE, A_NONE, 16'h0, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++)
         expectCycle($sformatf("halt/H%0d", i), M_NONE, A_NONE, 16'h0, 16'h0, 1'b0, 1'b0);
      pulseClear("halt");

      // add R1,R2,R3 with Stop high: completes, then HALT
      applyStimulus(32'h18918000, 1'b1, 1'b1);
      expectFetch("stop");
      expectCycle("stop/T3", M_YIN, A_NONE, 16'h0000, 16'h0004, 1'b1, 1'b0);
      expectCycle("stop/T4", M_ZIN, A_ADD, 16'h0000, 16'h0008, 1'b1, 1'b0);
      expectCycle("stop/T5", M_ZLO, A_NONE, 16'h0002, 16'h0000, 1'b1, 1'b0);
      Stop = 1'b0;
      expectCycle("stop/H0", M_NONE, A_NONE, 16'h0, 16'h0, 1'b0, 1'b0);
      expectCycle("stop/H1", M_NONE, A_NONE, 16'h0, 16'h0, 1'b0, 1'b0);
      pulseClear("stop");

      // Clear during T4 of an add abandons it
      applyStimulus(32'h18918000, 1'b1, 1'b0);
      expectFetch("abort");
      expectCycle("abort/T3", M_YIN, A_NONE, 16'h0000, 16'h0004, 1'b1, 1'b0);
      Clear = 1'b1;
      #1;
      checkOutput("abort/T4clr", {3'b0, strobeObs, aluObs, Rin, Rout, Run, Illegal},
                                 {3'b0, M_NONE, A_NONE, 16'h0, 16'h0, 1'b1, 1'b0});
      @(posedge Clock);
      #1;
      Clear = 1'b0;
      #1;
      expectFetch("restart");
      expectCycle("restart/T3", M_YIN, A_NONE, 16'h0000, 16'h0004, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
